// File: rtl/hazard_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_sequencer_pkg
// Brief   : Shared pipeline types and constants for the hazard sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } hs_state_t;

    localparam logic [4:0] REG_X0               = 5'd0;
    localparam int         DEFAULT_DRAIN_CYCLES = 3;
    localparam int         DEFAULT_MEM_TIMEOUT  = 255;

endpackage
`default_nettype wire

// File: rtl/hazard_sequencer_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module  : hazard_detect
// Brief   : Combinational load-use comparator between ID and ID/EX.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_detect
    import hazard_sequencer_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1_id,
    input  logic [4:0] id_rs2_id,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       idex_valid,
    input  logic       idex_mem_enable,
    input  logic       idex_mem_write,
    input  logic [4:0] idex_rd_id,
    output logic       load_use
);

    logic w_is_load;
    logic w_src_match;

    assign w_is_load   = idex_valid & idex_mem_enable & ~idex_mem_write & (idex_rd_id != REG_X0);
    assign w_src_match = (id_uses_rs1 & (id_rs1_id == idex_rd_id))
                       | (id_uses_rs2 & (id_rs2_id == idex_rd_id));
    assign load_use    = w_is_load & id_valid & w_src_match;

endmodule
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : hazard_sequencer
// Brief   : Stall/flush controller for the 5-stage pipeline.
//           Optional perf counters enabled by macro HAZARD_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int MEM_TIMEOUT  = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_id,
    input  logic [4:0]  id_rs2_id,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_is_halt,
    input  logic        idex_valid,
    input  logic        idex_mem_enable,
    input  logic        idex_mem_write,
    input  logic [4:0]  idex_rd_id,
    input  logic        ex_redirect,
    input  logic        exmem_mem_enable,
    input  logic        dmem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        memwb_bubble,
    output logic        is_halted,
    output logic        mem_timeout_err
`ifdef HAZARD_PERF_EN
   ,output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_flushes
`endif
);

    localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(DRAIN_CYCLES - 1);

    hs_state_t        r_state, w_state_next, w_eff_state;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_eff_cnt;
    logic [CNT_W-1:0] r_saved_cnt, w_saved_next;
    logic             r_ret_drain, w_ret_next;
    logic             r_is_halted, r_err, w_err_set;
    logic             w_mem_stall, w_load_use, w_halt_req;

    assign w_mem_stall = exmem_mem_enable & ~dmem_ready;
    assign w_halt_req  = id_valid & id_is_halt;

    hazard_detect u_hazard_detect (
        .id_valid        (id_valid),
        .id_rs1_id       (id_rs1_id),
        .id_rs2_id       (id_rs2_id),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .idex_valid      (idex_valid),
        .idex_mem_enable (idex_mem_enable),
        .idex_mem_write  (idex_mem_write),
        .idex_rd_id      (idex_rd_id),
        .load_use        (w_load_use)
    );

    // The dmem-ready cycle of a wait behaves exactly like the origin state,
    // with the drain count it had before the wait began.
    always_comb begin
        w_eff_state = r_state;
        w_eff_cnt   = r_cnt;
        if (r_state == ST_MEM_WAIT && !w_mem_stall) begin
            w_eff_state = r_ret_drain ? ST_DRAIN : ST_RUN;
            w_eff_cnt   = r_saved_cnt;
        end
    end

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        w_state_next = w_eff_state;
        w_cnt_next   = w_eff_cnt;
        w_saved_next = r_saved_cnt;
        w_ret_next   = r_ret_drain;
        w_err_set    = 1'b0;
        if (!reset) begin
            if (w_mem_stall && w_eff_state != ST_HALTED) begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_we     = 1'b0;
                memwb_bubble = 1'b1;
            end
            case (w_eff_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        w_state_next = ST_MEM_WAIT;
                        w_cnt_next   = CNT_W'(1);
                        w_saved_next = w_eff_cnt;
                        w_ret_next   = 1'b0;
                    end else if (ex_redirect) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (w_load_use) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (w_halt_req) begin
                        pc_we        = 1'b0;
                        ifid_flush   = 1'b1;
                        w_state_next = ST_DRAIN;
                        w_cnt_next   = '0;
                    end
                end
                ST_MEM_WAIT: begin
                    ifid_flush = r_ret_drain;
                    if (r_cnt == c_timeout) begin
                        w_err_set    = 1'b1;
                        w_state_next = ST_HALTED;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    pc_we      = 1'b0;
                    ifid_flush = 1'b1;
                    if (w_mem_stall) begin
                        w_state_next = ST_MEM_WAIT;
                        w_cnt_next   = CNT_W'(1);
                        w_saved_next = w_eff_cnt;
                        w_ret_next   = 1'b1;
                    end else if (w_eff_cnt == c_drain_last) begin
                        w_state_next = ST_HALTED;
                    end else begin
                        w_cnt_next = w_eff_cnt + CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    ifid_flush = 1'b1;
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_saved_cnt <= '0;
            r_ret_drain <= 1'b0;
            r_is_halted <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_saved_cnt <= w_saved_next;
            r_ret_drain <= w_ret_next;
            r_is_halted <= (r_state == ST_HALTED);
            r_err       <= r_err | w_err_set;
        end
    end

    assign is_halted       = r_is_halted;
    assign mem_timeout_err = r_err;

`ifdef HAZARD_PERF_EN
    logic        w_ev_stall, w_ev_bubble, w_ev_flush;
    logic [31:0] r_perf_stall, r_perf_bubble, r_perf_flush;

    assign w_ev_stall  = ~reset & w_mem_stall & (w_eff_state != ST_HALTED);
    assign w_ev_flush  = ~reset & ~w_mem_stall & (w_eff_state == ST_RUN) & ex_redirect;
    assign w_ev_bubble = ~reset & ~w_mem_stall & (w_eff_state == ST_RUN) & ~ex_redirect & w_load_use;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
            r_perf_flush  <= '0;
        end else begin
            if (w_ev_stall  && r_perf_stall  != '1) r_perf_stall  <= r_perf_stall  + 32'd1;
            if (w_ev_bubble && r_perf_bubble != '1) r_perf_bubble <= r_perf_bubble + 32'd1;
            if (w_ev_flush  && r_perf_flush  != '1) r_perf_flush  <= r_perf_flush  + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_bubbles      = r_perf_bubble;
    assign perf_flushes      = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_sequencer
// Brief   : Directed self-checking bench for hazard_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_is_halt;
    logic [4:0] id_rs1_id, id_rs2_id, idex_rd_id;
    logic       idex_valid, idex_mem_enable, idex_mem_write;
    logic       ex_redirect, exmem_mem_enable, dmem_ready;
    logic       pc_we, ifid_we, idex_we, exmem_we;
    logic       ifid_flush, idex_bubble, memwb_bubble;
    logic       is_halted, mem_timeout_err;
    logic [6:0] w_ctl;

    // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble}
    localparam logic [6:0] c_norm    = 7'b1111_000;
    localparam logic [6:0] c_lu      = 7'b0011_010;
    localparam logic [6:0] c_redir   = 7'b1111_110;
    localparam logic [6:0] c_stall   = 7'b0000_001;
    localparam logic [6:0] c_dstall  = 7'b0000_101;
    localparam logic [6:0] c_drain   = 7'b0111_100;
    localparam logic [6:0] c_halted  = 7'b0011_100;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_halt(id_is_halt),
        .idex_valid(idex_valid), .idex_mem_enable(idex_mem_enable),
        .idex_mem_write(idex_mem_write), .idex_rd_id(idex_rd_id),
        .ex_redirect(ex_redirect), .exmem_mem_enable(exmem_mem_enable),
        .dmem_ready(dmem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
        .is_halted(is_halted), .mem_timeout_err(mem_timeout_err)
    );

    assign w_ctl = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_halt = 0;
        id_rs1_id = 0; id_rs2_id = 0; idex_rd_id = 0;
        idex_valid = 0; idex_mem_enable = 0; idex_mem_write = 0;
        ex_redirect = 0; exmem_mem_enable = 0; dmem_ready = 1;
    endtask

    // LW x<rd> in ID/EX, consumer reading rs1/rs2 in ID
    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        idex_valid = 1; idex_mem_enable = 1; idex_mem_write = 0; idex_rd_id = rd;
        id_valid = 1; id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_id = rs1; id_rs2_id = rs2;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        adv();
        adv();
        reset = 0;
    endtask

    // Accept a halt, then run until is_halted, optionally stalling dmem mid-drain.
    task automatic run_halt(input int stall_at, input int stall_len, output int lat,
                            output logic pc_leak, output logic [6:0] stall_ctl);
        clear_inputs();
        id_valid = 1; id_is_halt = 1;
        #1;
        check("halt_accept_ctl", w_ctl, c_drain);
        lat = -1; pc_leak = 0; stall_ctl = c_norm;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            adv();
            clear_inputs();
            if (k >= stall_at && k < stall_at + stall_len) begin
                exmem_mem_enable = 1; dmem_ready = 0;
            end else if (k == stall_at + stall_len) begin
                exmem_mem_enable = 1; dmem_ready = 1;
            end
            #1;
            if (k == stall_at) stall_ctl = w_ctl;
            if (is_halted) lat = k;
            else pc_leak = pc_leak | pc_we;
        end
    endtask

    initial begin
        int lat0, lat1;
        logic leak, bad;
        logic [6:0] sctl;

        // Reset dominates a pending dmem stall.
        clear_inputs();
        reset = 1;
        exmem_mem_enable = 1; dmem_ready = 0;
        adv();
        #1;
        check("reset_ctl", w_ctl, c_norm);
        check("reset_halted", is_halted, 0);
        check("reset_err", mem_timeout_err, 0);
        adv();
        reset = 0;
        clear_inputs();
        #1;
        check("idle_ctl", w_ctl, c_norm);

        // Load-use on rs1, then the bubble clears the hazard.
        set_load_use(5'd5, 5'd5, 5'd1);
        #1;
        check("lu_rs1", w_ctl, c_lu);
        adv();
        idex_valid = 0;
        #1;
        check("lu_after", w_ctl, c_norm);
        adv();
        set_load_use(5'd0, 5'd0, 5'd1);
        #1;
        check("lu_x0", w_ctl, c_norm);
        adv();
        set_load_use(5'd7, 5'd1, 5'd7);
        #1;
        check("lu_rs2", w_ctl, c_lu);
        idex_mem_write = 1;
        #1;
        check("store_no_lu", w_ctl, c_norm);
        idex_mem_write = 0;
        id_uses_rs2 = 0;
        #1;
        check("rs2_unused", w_ctl, c_norm);

        // Redirect beats a wrong-path load-use.
        adv();
        set_load_use(5'd5, 5'd5, 5'd1);
        ex_redirect = 1;
        #1;
        check("redir_over_lu", w_ctl, c_redir);

        // Four-cycle dmem wait; ready cycle uses RUN outputs.
        adv();
        clear_inputs();
        exmem_mem_enable = 1; dmem_ready = 0; ex_redirect = 1;
        #1;
        check("stall_over_redir", w_ctl, c_stall);
        ex_redirect = 0;
        bad = 0;
        for (int k = 1; k < 4; k++) begin
            adv();
            #1;
            bad = bad | (w_ctl !== c_stall);
        end
        check("stall_4cyc", bad, 0);
        adv();
        dmem_ready = 1;
        set_load_use(5'd9, 5'd9, 5'd2);
        #1;
        check("ready_cycle_run", w_ctl, c_lu);
        adv();
        clear_inputs();
        #1;
        check("post_wait_ctl", w_ctl, c_norm);
        check("post_wait_err", mem_timeout_err, 0);

        // Halt drain, unstalled.
        run_halt(0, 0, lat0, leak, sctl);
        check("halt_lat", lat0, 5);
        check("halt_pc_frozen", leak, 0);
        check("halted_ctl", w_ctl, c_halted);

        // Halt drain with a two-cycle dmem stall.
        do_reset();
        #1;
        check("rst_after_halt", is_halted, 0);
        run_halt(2, 2, lat1, leak, sctl);
        check("halt_stall_lat", lat1, 7);
        check("halt_stall_delta", lat1 - lat0, 2);
        check("halt_stall_pc", leak, 0);
        check("drain_stall_ctl", sctl, c_dstall);

        // Reset in the middle of a drain.
        do_reset();
        id_valid = 1; id_is_halt = 1;
        #1;
        check("halt2_accept", w_ctl, c_drain);
        adv();
        clear_inputs();
        #1;
        check("drain_ctl", w_ctl, c_drain);
        adv();
        reset = 1;
        #1;
        check("reset_in_drain_ctl", w_ctl, c_norm);
        adv();
        reset = 0;
        #1;
        check("after_drain_rst_ctl", w_ctl, c_norm);
        check("after_drain_rst_halted", is_halted, 0);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            adv();
            #1;
            bad = bad | (w_ctl !== c_norm) | is_halted;
        end
        check("stays_run", bad, 0);

        // dmem never ready: error trap after 8 wait cycles.
        clear_inputs();
        exmem_mem_enable = 1; dmem_ready = 0;
        #1;
        check("to_stall", w_ctl, c_stall);
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            adv();
            #1;
            bad = bad | (w_ctl !== c_stall) | mem_timeout_err;
        end
        check("wait_no_err", bad, 0);
        adv();
        #1;
        check("timeout_err", mem_timeout_err, 1);
        check("timeout_halted_ctl", w_ctl, c_halted);
        check("timeout_halted_lag", is_halted, 0);
        adv();
        #1;
        check("timeout_is_halted", is_halted, 1);
        check("err_sticky", mem_timeout_err, 1);
        do_reset();
        #1;
        check("err_cleared", mem_timeout_err, 0);
        check("err_rst_ctl", w_ctl, c_norm);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives write-enable and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use hazards, EX-stage branch/jump redirects, multi-cycle data-memory waits and halt draining.
- Mealy outputs are computed combinationally from the registered FSM state and current stage inputs.

Parameters:
- DRAIN_CYCLES, 3, cycles from halt entering ID/EX until it commits at WB; is_halted rises afterwards.
- MEM_TIMEOUT, 255, max consecutive dmem-wait cycles before the error trap.
- CNT_W, 8, width of the wait/drain counter; must hold max(DRAIN_CYCLES, MEM_TIMEOUT).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1_id, id_rs2_id  in  5 each  ID source register indices
- id_uses_rs1, id_uses_rs2  in  1 each  source actually read
- id_is_halt  in  1  ID instruction is ECALL-halt
- idex_valid, idex_mem_enable, idex_mem_write  in  1 each  ID/EX stage flags
- idex_rd_id  in  5  ID/EX destination index
- ex_redirect  in  1  EX resolved a control transfer to a non-predicted PC
- exmem_mem_enable  in  1  MEM stage accesses dmem
- dmem_ready  in  1  dmem completes this cycle
- pc_we, ifid_we, idex_we, exmem_we  out  1 each  register load enables
- ifid_flush, idex_bubble, memwb_bubble  out  1 each  load a NOP / clear valid instead of input
- is_halted  out  1  registered; pipeline drained after halt
- mem_timeout_err  out  1  registered, sticky

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED. Reset → RUN, cnt=0, is_halted=0, mem_timeout_err=0. While reset is high, comb outputs are RUN defaults; pipeline registers' own reset dominates.
- Defaults: all *_we=1; flush and bubble signals=0.
- mem_stall = exmem_mem_enable & ~dmem_ready.
- load_use = idex_valid & idex_mem_enable & ~idex_mem_write & idex_rd_id≠0 & id_valid & ((id_uses_rs1 & id_rs1_id==idex_rd_id) | (id_uses_rs2 & id_rs2_id==idex_rd_id)).
- Priority, highest first: mem_stall > ex_redirect > load_use > halt.
- mem_stall, in RUN/MEM_WAIT/DRAIN:
  - pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1.
  - Freeze is same-cycle, not registered.
  - RUN→MEM_WAIT with cnt=1. In MEM_WAIT cnt increments per stalled cycle.
  - When cnt==MEM_TIMEOUT with still no ready: set mem_timeout_err, go to HALTED.
- dmem_ready in MEM_WAIT:
  - Return to the saved origin state (RUN or DRAIN; 1-bit return flag). cnt is restored to its pre-wait value in DRAIN.
  - The ready cycle itself uses normal RUN/DRAIN outputs.
- ex_redirect (no mem_stall): pc_we=1 (PC loads target), ifid_flush=1, idex_bubble=1. A load_use in the same cycle is ignored as wrong-path.
- load_use (no stall, no redirect): pc_we=0, ifid_we=0, idex_bubble=1. Exactly one bubble; the next cycle re-evaluates, normally clean.
- Halt: id_valid & id_is_halt, with no stall/redirect/load_use, in RUN:
  - Halt advances into ID/EX. Same cycle: pc_we=0, ifid_flush=1. Next state DRAIN, cnt=0.
  - A load_use on the halt delays acceptance one cycle.
- DRAIN:
  - pc_we=0, ifid_flush=1 every cycle; cnt increments except during mem_stall.
  - When cnt==DRAIN_CYCLES-1 advances: go to HALTED.
- HALTED: pc_we=ifid_we=0, ifid_flush=1; is_halted=1 registered (rises the cycle after entry). Only reset exits.
- Reset asserted mid-MEM_WAIT or mid-DRAIN: unconditional return to RUN, counters cleared, error cleared.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cycles (32), perf_bubbles (32), perf_flushes (32); all reset to 0, saturating.
  - stall_cycles counts mem_stall cycles; bubbles counts load_use bubbles; flushes counts ex_redirect events.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds:
  - state encoding typedef (RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3);
  - REG_X0=5'd0;
  - default DRAIN_CYCLES/MEM_TIMEOUT constants.
- Sub-module hazard_detect: pure combinational load_use comparator, reused by the forwarding unit.

Test Plan:
- LW x5 in ID/EX, ADD x6,x5,x1 in ID → one cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle all enables 1. Same with rd=x0 → no bubble.
- ex_redirect=1 together with load_use=1 → pc_we=1, ifid_flush=1, idex_bubble=1, no freeze.
- exmem_mem_enable=1, dmem_ready low 4 cycles → all we=0, memwb_bubble=1 for 4 cycles; state returns to RUN on ready; err=0.
- dmem_ready held low with MEM_TIMEOUT=8 → mem_timeout_err=1 after 8 wait cycles, HALTED; reset clears it.
- Halt in ID, DRAIN_CYCLES=3, 2-cycle mem_stall during drain → is_halted rises exactly 2 cycles later than the unstalled case; pc_we=0 throughout.
- Reset asserted during DRAIN → next cycle state RUN, is_halted=0, all we=1.
